// File: rtl/spmac_pkg.sv
// ----------------------------------------------------------------------------
// spmac_pkg
// Shared definitions for the serial/parallel signed multiply-accumulate unit:
// the controller state type, default widths and helpers that derive the
// product, accumulator and counter widths from the user parameters.
// No ports (package).
// Optional feature macro used by this block: SPMAC_ROUND_EN (see spmac_scale).
// ----------------------------------------------------------------------------
package spmac_pkg;

   localparam int DEF_SIG_W   = 16;
   localparam int DEF_COEF_W  = 10;
   localparam int DEF_OUT_W   = 16;
   localparam int DEF_GUARD_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MUL    = 2'd1,
      FINISH = 2'd2
   } spmac_state_t;

   // The exact product of an SIG_W-bit and a COEF_W-bit signed number always
   // fits in SIG_W+COEF_W bits, including the most-negative times most-negative
   // corner case.
   function automatic int prod_width(input int sig_w, input int coef_w);
      return sig_w + coef_w;
   endfunction

   // The accumulator adds guard bits on top of the product so that several
   // taps can be summed before the sum can wrap.
   function automatic int sum_width(input int sig_w, input int coef_w, input int guard_w);
      return prod_width(sig_w, coef_w) + guard_w;
   endfunction

   // Bit counter width; never allowed to collapse to zero bits.
   function automatic int cnt_width(input int coef_w);
      return (coef_w > 1) ? $clog2(coef_w) : 1;
   endfunction

endpackage

// File: rtl/spmac_if.sv
// ----------------------------------------------------------------------------
// spmac_if
// Request/result bundle of the multiply-accumulate unit.
//   start      : request, sampled only while the unit is idle
//   accum      : 0 = sum replaced by product, 1 = sum += product
//   sig_in     : signed multiplicand (SIG_W)
//   coef_in    : signed coefficient, Q1.(COEF_W-1) (COEF_W)
//   ready      : high while the unit is idle
//   done       : one-cycle pulse when result_out/sat are updated
//   result_out : scaled, saturated sum (OUT_W)
//   sat        : 1 if the last result was clipped
// Modports: master (requester side), slave (the multiply-accumulate unit).
// ----------------------------------------------------------------------------
interface spmac_if
   import spmac_pkg::*;
#(
   parameter int SIG_W  = DEF_SIG_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int OUT_W  = DEF_OUT_W
);

   logic                     start;
   logic                     accum;
   logic signed [SIG_W-1:0]  sig_in;
   logic signed [COEF_W-1:0] coef_in;
   logic                     ready;
   logic                     done;
   logic signed [OUT_W-1:0]  result_out;
   logic                     sat;

   modport master (
      output start, accum, sig_in, coef_in,
      input  ready, done, result_out, sat
   );

   modport slave (
      input  start, accum, sig_in, coef_in,
      output ready, done, result_out, sat
   );

endinterface

// File: rtl/spmac_scale.sv
// ----------------------------------------------------------------------------
// spmac_scale
// Combinational output stage: takes a Q(COEF_W-1)-scaled accumulator value,
// optionally rounds it, shifts it back to the signal scale and saturates it
// to OUT_W bits.
//   s      in  SUM_W  signed accumulator value
//   result out OUT_W  scaled, saturated value
//   sat    out 1      1 when the scaled value had to be clipped
// Macro SPMAC_ROUND_EN: when defined, round half toward +inf before the
// shift; when undefined, truncate (floor).
// ----------------------------------------------------------------------------
module spmac_scale
   import spmac_pkg::*;
#(
   parameter int SUM_W  = sum_width(DEF_SIG_W, DEF_COEF_W, DEF_GUARD_W),
   parameter int COEF_W = DEF_COEF_W,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic signed [SUM_W-1:0] s,
   output logic signed [OUT_W-1:0] result,
   output logic                    sat
);

   // One extra bit so the rounding offset can never wrap the sum.
   localparam int EXT_W = SUM_W + 1;

   localparam logic signed [EXT_W-1:0] MAX_Q = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] MIN_Q = ~MAX_Q;

`ifdef SPMAC_ROUND_EN
   localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (COEF_W-2);
`endif

   logic signed [EXT_W-1:0] s_ext;
   logic signed [EXT_W-1:0] biased;
   logic signed [EXT_W-1:0] q;

   // Bias (optionally), arithmetic-shift back to signal scale, then clip.
   // The arithmetic shift is a floor, so adding half an LSB first gives
   // round-half-up; without the bias the result is plain truncation.
   always_comb begin
      s_ext  = {s[SUM_W-1], s};
`ifdef SPMAC_ROUND_EN
      biased = s_ext + HALF;
`else
      biased = s_ext;
`endif
      q      = biased >>> (COEF_W-1);
      sat    = 1'b0;
      result = q[OUT_W-1:0];
      if (q > MAX_Q) begin
         sat    = 1'b1;
         result = MAX_Q[OUT_W-1:0];
      end else if (q < MIN_Q) begin
         sat    = 1'b1;
         result = MIN_Q[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/spmac_serial.sv
// ----------------------------------------------------------------------------
// spmac_serial
// Serial/parallel signed multiply-accumulate unit. The coefficient is
// consumed MSB-first, one bit per clock, building the exact two's-complement
// product sig*coef; the sign bit (weight -2^(COEF_W-1)) is handled by
// subtracting the multiplicand on the first cycle, so no correction step is
// needed. A final cycle adds the product to (or replaces) the running sum and
// scales/saturates it to OUT_W bits.
// Ports:
//   clk     in  clock
//   rst_an  in  asynchronous, active-low reset (aborts any operation)
//   bus     spmac_if.slave: start, accum, sig_in, coef_in in;
//           ready, done, result_out, sat out
// Timing: start accepted at edge 0 -> done pulses after edge COEF_W+1;
// back-to-back operations every COEF_W+2 cycles.
// Macro SPMAC_ROUND_EN: selects round-half-up instead of truncation in the
// output scaling (stored sum stays unrounded).
// ----------------------------------------------------------------------------
module spmac_serial
   import spmac_pkg::*;
#(
   parameter int SIG_W   = DEF_SIG_W,
   parameter int COEF_W  = DEF_COEF_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int GUARD_W = DEF_GUARD_W
) (
   input  logic   clk,
   input  logic   rst_an,
   spmac_if.slave bus
);

   localparam int PROD_W = prod_width(SIG_W, COEF_W);
   localparam int SUM_W  = sum_width(SIG_W, COEF_W, GUARD_W);
   localparam int CNT_W  = cnt_width(COEF_W);

   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(COEF_W-1);

   spmac_state_t              state;
   logic signed [PROD_W-1:0]  prod;
   logic signed [SUM_W-1:0]   sum;
   logic [COEF_W-1:0]         coefreg;
   logic signed [SIG_W-1:0]   sigreg;
   logic                      accreg;
   logic [CNT_W-1:0]          cnt;

   logic                      ready_reg;
   logic                      done_reg;
   logic signed [OUT_W-1:0]   result_reg;
   logic                      sat_reg;

   logic signed [PROD_W-1:0]  sig_ext;
   logic signed [PROD_W-1:0]  addend;
   logic signed [SUM_W-1:0]   s_next;
   logic signed [OUT_W-1:0]   scaled;
   logic                      scaled_sat;

   // Partial-product term for the current coefficient bit. On the first MUL
   // cycle the bit under test is the sign bit, whose weight is negative, so
   // the multiplicand is subtracted instead of added.
   always_comb begin
      sig_ext = {{COEF_W{sigreg[SIG_W-1]}}, sigreg};
      addend  = '0;
      if (coefreg[COEF_W-1]) begin
         addend = (cnt == CNT_FIRST) ? -sig_ext : sig_ext;
      end
   end

   // Value the accumulator takes in FINISH: either the fresh product or the
   // product added to the previous sum, sign-extended into the guard bits.
   always_comb begin
      s_next = (accreg ? sum : '0) + {{GUARD_W{prod[PROD_W-1]}}, prod};
   end

   spmac_scale #(
      .SUM_W  (SUM_W),
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W)
   ) u_scale (
      .s      (s_next),
      .result (scaled),
      .sat    (scaled_sat)
   );

   // Controller and datapath. IDLE waits for start and latches the operands;
   // MUL shifts the coefficient out MSB-first while doubling-and-adding into
   // prod (Horner form), so after COEF_W cycles prod is the exact product;
   // FINISH commits the new sum and the scaled result and pulses done.
   // ready and done are registered from the next state so they line up with
   // the state the unit is actually in.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         state      <= IDLE;
         prod       <= '0;
         sum        <= '0;
         coefreg    <= '0;
         sigreg     <= '0;
         accreg     <= 1'b0;
         cnt        <= '0;
         ready_reg  <= 1'b1;
         done_reg   <= 1'b0;
         result_reg <= '0;
         sat_reg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  sigreg    <= bus.sig_in;
                  coefreg   <= bus.coef_in;
                  accreg    <= bus.accum;
                  prod      <= '0;
                  cnt       <= CNT_FIRST;
                  ready_reg <= 1'b0;
                  state     <= MUL;
               end else begin
                  ready_reg <= 1'b1;
               end
            end
            MUL: begin
               prod    <= (prod <<< 1) + addend;
               coefreg <= coefreg << 1;
               cnt     <= cnt - 1'b1;
               if (cnt == '0) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               sum        <= s_next;
               result_reg <= scaled;
               sat_reg    <= scaled_sat;
               done_reg   <= 1'b1;
               ready_reg  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state     <= IDLE;
               ready_reg <= 1'b1;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Drive the interface outputs straight from the registers.
   assign bus.ready      = ready_reg;
   assign bus.done       = done_reg;
   assign bus.result_out = result_reg;
   assign bus.sat        = sat_reg;

endmodule

// File: tb/tb_spmac_serial.sv
// ----------------------------------------------------------------------------
// tb_spmac_serial
// Self-checking bench for spmac_serial with default widths. A behavioural
// model (integer product, integer sum with modulo wrap, floor/round shift,
// clip) predicts ready/done/result_out/sat every cycle; directed sequences
// add hand-computed literal expectations, then a randomized phase runs.
// Honours SPMAC_ROUND_EN for the expected rounding results.
// ----------------------------------------------------------------------------
module tb_spmac_serial;
   import spmac_pkg::*;

   localparam int SIG_W   = 16;
   localparam int COEF_W  = 10;
   localparam int OUT_W   = 16;
   localparam int GUARD_W = 4;
   localparam int SUM_W   = sum_width(SIG_W, COEF_W, GUARD_W);

   logic clk    = 1'b0;
   logic rst_an = 1'b0;

   int total = 0;
   int bad   = 0;

   spmac_if #(.SIG_W(SIG_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

   spmac_serial #(
      .SIG_W   (SIG_W),
      .COEF_W  (COEF_W),
      .OUT_W   (OUT_W),
      .GUARD_W (GUARD_W)
   ) dut (
      .clk    (clk),
      .rst_an (rst_an),
      .bus    (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Reference model state: cycles remaining in the current operation
   // (0 = idle), latched operands, the running sum and the visible outputs.
   int     m_rem    = 0;
   longint m_sig    = 0;
   longint m_coef   = 0;
   longint m_sum    = 0;
   longint m_result = 0;
   bit     m_acc    = 1'b0;
   bit     m_done   = 1'b0;
   bit     m_sat    = 1'b0;

   function automatic longint wrap_sum(input longint v);
      longint m;
      longint r;
      m = 64'sd1 <<< SUM_W;
      r = v & (m - 1);
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

   function automatic longint next_sum(input bit acc, input longint old, input longint p);
      return wrap_sum((acc ? old : 64'sd0) + p);
   endfunction

   function automatic longint quantise(input longint s);
`ifdef SPMAC_ROUND_EN
      return (s + (64'sd1 <<< (COEF_W-2))) >>> (COEF_W-1);
`else
      return s >>> (COEF_W-1);
`endif
   endfunction

   function automatic longint clip_q(input longint q);
      longint hi;
      hi = (64'sd1 <<< (OUT_W-1)) - 1;
      if (q > hi) return hi;
      if (q < -hi - 1) return -hi - 1;
      return q;
   endfunction

   function automatic bit clipped(input longint q);
      return clip_q(q) != q;
   endfunction

   // Model update: an accepted start occupies COEF_W+1 edges; on the last
   // one the result is produced. Reset clears everything immediately.
   always @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         m_rem    <= 0;
         m_sum    <= 0;
         m_result <= 0;
         m_sat    <= 1'b0;
         m_done   <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_sum    <= next_sum(m_acc, m_sum, m_sig * m_coef);
               m_result <= clip_q(quantise(next_sum(m_acc, m_sum, m_sig * m_coef)));
               m_sat    <= clipped(quantise(next_sum(m_acc, m_sum, m_sig * m_coef)));
               m_done   <= 1'b1;
            end
         end else if (bus.start) begin
            m_sig  <= longint'($signed(bus.sig_in));
            m_coef <= longint'($signed(bus.coef_in));
            m_acc  <= bus.accum;
            m_rem  <= COEF_W + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      checkOutput("ready",  longint'(bus.ready), longint'(m_rem == 0));
      checkOutput("done",   longint'(bus.done), longint'(m_done));
      checkOutput("result", longint'($signed(bus.result_out)), m_result);
      checkOutput("sat",    longint'(bus.sat), longint'(m_sat));
   end

   // Wait for done with a bound; counts falling edges since the call.
   task automatic waitDone(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 40);
      if (!bus.done) checkOutput("done_timeout", 0, 1);
   endtask

   // One operation: start for one cycle, wait for done, and report the
   // edges from the accepting edge to done plus how long ready was low.
   task automatic applyStimulus(input longint sig, input longint coef, input bit acc,
                                output int lat, output int ready_low);
      bus.start   = 1'b1;
      bus.sig_in  = SIG_W'(sig);
      bus.coef_in = COEF_W'(coef);
      bus.accum   = acc;
      @(negedge clk);
      bus.start = 1'b0;
      lat       = 0;
      ready_low = bus.ready ? 0 : 1;
      while (!bus.done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!bus.ready) ready_low++;
      end
      if (!bus.done) checkOutput("op_timeout", 0, 1);
   endtask

   // Literal check of the DUT outputs and of the model itself.
   task automatic checkLiteral(input string name, input longint exp_res, input bit exp_sat);
      checkOutput({name, "_res"}, longint'($signed(bus.result_out)), exp_res);
      checkOutput({name, "_sat"}, longint'(bus.sat), longint'(exp_sat));
      checkOutput({name, "_model"}, m_result, exp_res);
   endtask

   initial begin
      int lat;
      int rlow;
      int n;
      int dones;
      longint seen;
      longint exp_acc [11] = '{5000, 10000, 15000, 20000, 25000, 30000,
                               32767, 32767, 32767, 32767, 32767};

      bus.start   = 1'b0;
      bus.accum   = 1'b0;
      bus.sig_in  = '0;
      bus.coef_in = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", longint'(bus.ready), 1);
      checkOutput("rst_done", longint'(bus.done), 0);
      checkOutput("rst_result", longint'($signed(bus.result_out)), 0);
      checkOutput("rst_sat", longint'(bus.sat), 0);
      rst_an = 1'b1;
      @(negedge clk);

      // Basic product, latency and busy window.
      applyStimulus(1000, 256, 1'b0, lat, rlow);
      checkOutput("latency", lat, 11);
      checkOutput("ready_low", rlow, 11);
      checkLiteral("p1000x256", 500, 1'b0);

      // Most-negative corner cases.
      applyStimulus(-32768, -512, 1'b0, lat, rlow);
      checkLiteral("negxneg", 32767, 1'b1);
      applyStimulus(-32768, 511, 1'b0, lat, rlow);
      checkLiteral("negx511", -32704, 1'b0);

      // Back-to-back accumulation with start held high.
      bus.start   = 1'b1;
      bus.sig_in  = 16'sd10000;
      bus.coef_in = 10'sd256;
      bus.accum   = 1'b0;
      @(negedge clk);
      bus.accum = 1'b1;
      for (int i = 0; i < 11; i++) begin
         waitDone(n);
         if (i > 0) checkOutput("b2b_period", n, 12);
         checkLiteral("accum", exp_acc[i], i >= 6);
      end
      bus.start = 1'b0;
      bus.accum = 1'b0;
      @(negedge clk);

      // Rounding versus truncation.
      applyStimulus(3, 256, 1'b0, lat, rlow);
`ifdef SPMAC_ROUND_EN
      checkLiteral("pos_half", 2, 1'b0);
`else
      checkLiteral("pos_half", 1, 1'b0);
`endif
      applyStimulus(-3, 256, 1'b0, lat, rlow);
`ifdef SPMAC_ROUND_EN
      checkLiteral("neg_half", -1, 1'b0);
`else
      checkLiteral("neg_half", -2, 1'b0);
`endif

      // A start during MUL cycle 4 must be ignored.
      bus.start   = 1'b1;
      bus.sig_in  = 16'sd1000;
      bus.coef_in = 10'sd256;
      bus.accum   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start   = 1'b1;
      bus.sig_in  = 16'sd7;
      bus.coef_in = 10'sd100;
      bus.accum   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      seen  = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) begin
            dones++;
            seen = longint'($signed(bus.result_out));
         end
      end
      checkOutput("ignored_start_dones", dones, 1);
      checkOutput("ignored_start_result", seen, 500);

      // Asynchronous reset during MUL cycle 5 aborts the operation.
      bus.start   = 1'b1;
      bus.sig_in  = 16'sd2000;
      bus.coef_in = 10'sd256;
      bus.accum   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_an = 1'b0;
      #1;
      checkOutput("abort_ready", longint'(bus.ready), 1);
      checkOutput("abort_done", longint'(bus.done), 0);
      checkOutput("abort_result", longint'($signed(bus.result_out)), 0);
      repeat (2) @(negedge clk);
      rst_an = 1'b1;
      dones  = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      checkOutput("abort_no_done", dones, 0);
      applyStimulus(1000, 256, 1'b1, lat, rlow);
      checkLiteral("after_abort", 500, 1'b0);

      // Randomized traffic: random starts (including during busy cycles),
      // random operands with occasional extremes, random accumulate.
      repeat (900) begin
         bus.start = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0:       bus.sig_in = 16'sh8000;
            1:       bus.sig_in = 16'sh7fff;
            default: bus.sig_in = SIG_W'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       bus.coef_in = 10'sh200;
            1:       bus.coef_in = 10'sh1ff;
            default: bus.coef_in = COEF_W'($urandom);
         endcase
         bus.accum = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (30) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
